// File: rtl/icache_loader_pkg.sv
// Shared types for the icache block loader: word type, icache geometry,
// loader state encoding and the latched load request.
package icache_loader_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned ICACHE_DEPTH = 32;
  localparam int unsigned ICACHE_IDX_W = 5;
  localparam int unsigned COUNT_W      = 6;
  localparam int unsigned WAIT_W       = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } ld_state_e;

  // Operands captured when a load is accepted.
  typedef struct packed {
    word_t              base;
    logic [COUNT_W-1:0] count;
  } ld_req_t;

  // Requests larger than the icache are limited to its depth.
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] c);
    return (c > COUNT_W'(ICACHE_DEPTH)) ? COUNT_W'(ICACHE_DEPTH) : c;
  endfunction

endpackage

// File: rtl/icache_loader.sv
// Block loader: copies count consecutive words from backing memory starting
// at base_addr into icache entries 0..count-1, one word at a time, aborting
// with error if memory stays silent for TIMEOUT cycles on any word.
//
// Ports:
//   clk, nrst            clock, async active-low reset
//   start                load request (sampled only when idle)
//   base_addr, count     first word address, number of words (clamped to 32)
//   mem_ren, mem_addr    memory read request/address, held until mem_ready
//   mem_ready, mem_rdata memory acknowledge and same-cycle read data
//   write, write_addr,   icache write port
//   write_data
//   busy                 high whenever not idle (fetch stall)
//   done, error          completion pulse; error marks a timeout abort
module icache_loader
  import icache_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic [WORD_W-1:0]       base_addr,
  input  logic [COUNT_W-1:0]      count,
  output logic                    mem_ren,
  output logic [WORD_W-1:0]       mem_addr,
  input  logic                    mem_ready,
  input  logic [WORD_W-1:0]       mem_rdata,
  output logic                    write,
  output logic [ICACHE_IDX_W-1:0] write_addr,
  output logic [WORD_W-1:0]       write_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  ld_state_e          r_state, w_state_nxt;
  ld_req_t            r_req, w_req_nxt;
  logic [COUNT_W-1:0] r_idx, w_idx_nxt;
  logic [WAIT_W-1:0]  r_wait, w_wait_nxt;
  logic               w_capture;
  logic               w_abort;
  logic [WORD_W-1:0]  w_mem_addr;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_idx_nxt   = r_idx;
    w_wait_nxt  = r_wait;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_req_nxt.base  = base_addr;
          w_req_nxt.count = clamp_count(count);
          w_idx_nxt       = '0;
          w_wait_nxt      = '0;
          w_state_nxt     = (count == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          w_capture   = 1'b1;
          w_wait_nxt  = '0;
          w_state_nxt = ST_WRITE;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
          // This idle cycle is the TIMEOUT-th one for the current word.
          if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_WRITE: begin
        w_idx_nxt   = r_idx + COUNT_W'(1);
        w_state_nxt = (w_idx_nxt == r_req.count) ? ST_FIN : ST_REQ;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address of the word the next REQ cycle will present; wraps modulo 2^32.
  assign w_mem_addr = w_req_nxt.base + WORD_W'(w_idx_nxt);

  // Operand, index and wait-counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_req  <= '0;
      r_idx  <= '0;
      r_wait <= '0;
    end else begin
      r_req  <= w_req_nxt;
      r_idx  <= w_idx_nxt;
      r_wait <= w_wait_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_ren    <= 1'b0;
      mem_addr   <= '0;
      write      <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_ren <= (w_state_nxt == ST_REQ);
      if (w_state_nxt == ST_REQ) mem_addr <= w_mem_addr;
      write <= w_capture;
      // Write port holds its last value outside WRITE.
      if (w_capture) begin
        write_addr <= r_idx[ICACHE_IDX_W-1:0];
        write_data <= mem_rdata;
      end
      busy  <= (w_state_nxt != ST_IDLE);
      done  <= (w_state_nxt == ST_FIN);
      error <= w_abort;
    end
  end

endmodule

// File: tb/tb_icache_loader.sv
// Scoreboard bench for icache_loader: stimulus pushes expected memory
// addresses, icache writes and done events; monitors pop and compare.
module tb_icache_loader;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [31:0] base_addr;
  logic [5:0]  count;
  logic        mem_ren, mem_ren_t;
  logic [31:0] mem_addr, mem_addr_t;
  logic        mem_ready;
  logic        mem_ready_t;
  logic [31:0] mem_rdata;
  logic        write, write_t;
  logic [4:0]  write_addr, write_addr_t;
  logic [31:0] write_data, write_data_t;
  logic        busy, busy_t;
  logic        done, done_t;
  logic        error, error_t;

  icache_loader dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr), .count(count),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .write(write), .write_addr(write_addr), .write_data(write_data),
    .busy(busy), .done(done), .error(error)
  );

  // Second instance with a short timeout and a memory that never answers.
  icache_loader #(.TIMEOUT(4)) dut_t (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr), .count(count),
    .mem_ren(mem_ren_t), .mem_addr(mem_addr_t), .mem_ready(mem_ready_t), .mem_rdata(mem_rdata),
    .write(write_t), .write_addr(write_addr_t), .write_data(write_data_t),
    .busy(busy_t), .done(done_t), .error(error_t)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic err; int lat; } dn_t;

  logic [31:0] q_addr[$];
  wr_t         q_wr[$];
  dn_t         q_done[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int t_start = 0;
  int mem_delay = 0;
  int rsp_wait  = 0;
  logic stray = 1'b0;
  logic prev_ren = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=0x%08h req=0x%08h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    n_total++;
    n_bad++;
    $display("FAIL %s act=0x%08h req=none", nm, act);
  endtask

  // Memory model: answers after mem_delay wait cycles, data = ~address.
  always @(negedge clk) begin
    mem_ready_t = 1'b0;
    if (nrst && mem_ren) begin
      if (rsp_wait == mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = ~mem_addr;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
      rsp_wait++;
    end else begin
      mem_ready = stray;
      mem_rdata = 32'hBAD0_0000 | 32'(cyc);
      rsp_wait  = 0;
    end
  end

  // Monitor: each new memory request address.
  always @(negedge clk) begin
    if (nrst && mem_ren && !prev_ren) begin
      if (q_addr.size() == 0) unexpected("mem_req", mem_addr);
      else chk("mem_addr", mem_addr, q_addr.pop_front());
    end
    prev_ren = mem_ren;
  end

  // Monitor: icache writes.
  always @(negedge clk) begin
    if (write) begin
      if (q_wr.size() == 0) unexpected("icache_write", {27'd0, write_addr});
      else begin
        wr_t e;
        e = q_wr.pop_front();
        chk("write_addr", {27'd0, write_addr}, {27'd0, e.a});
        chk("write_data", write_data, e.d);
      end
    end
  end

  // Monitor: completion pulses, error flag and latency from start.
  always @(negedge clk) begin
    if (done) begin
      if (q_done.size() == 0) unexpected("done", 32'(cyc - t_start));
      else begin
        dn_t e;
        e = q_done.pop_front();
        chk("done_error", {31'd0, error}, {31'd0, e.err});
        chk("done_latency", 32'(cyc - t_start), 32'(e.lat));
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Issue a load and push its expected addresses, writes and done event.
  task automatic load(input logic [31:0] b, input logic [5:0] c, input int dly);
    int n;
    logic [31:0] a;
    wr_t w;
    dn_t d;
    n = (c > 6'd32) ? 32 : int'(c);
    mem_delay = dly;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(i);
      q_addr.push_back(a);
      w.a = 5'(i);
      w.d = ~a;
      q_wr.push_back(w);
    end
    d.err = 1'b0;
    d.lat = 2 * n + 1 + n * dly;
    q_done.push_back(d);
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stray_start(input logic [31:0] b, input logic [5:0] c);
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    @(negedge clk);
    start = 1'b0; base_addr = 32'h0; count = 6'd0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || busy_t) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) unexpected("idle_timeout", 32'(k));
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_ren"}, {31'd0, mem_ren}, 32'd0);
    chk({tag, "_write"},   {31'd0, write},   32'd0);
    chk({tag, "_busy"},    {31'd0, busy},    32'd0);
    chk({tag, "_done"},    {31'd0, done},    32'd0);
    chk({tag, "_error"},   {31'd0, error},   32'd0);
  endtask

  initial begin
    int ren, wr, lat, k;
    logic seen;
    nrst = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    mem_ready = 1'b0; mem_ready_t = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_busy_t", {31'd0, busy_t}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Four words, memory answers immediately: done in cycle 9.
    load(32'h0000_0100, 6'd4, 0);
    wait_idle();

    // Three words, five wait cycles each: done in cycle 22.
    load(32'h0000_2000, 6'd3, 5);
    wait_idle();

    // Timeout instance: four request cycles, no writes, done+error in cycle 5.
    load(32'h0000_0040, 6'd2, 0);
    ren = 0; wr = 0; lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_ren_t) ren++;
      if (write_t) wr++;
      if (done_t) begin
        seen = 1'b1;
        lat = cyc - t_start;
        chk("to_error", {31'd0, error_t}, 32'd1);
      end else @(negedge clk);
    end
    chk("to_done_seen", {31'd0, seen}, 32'd1);
    chk("to_ren_cycles", 32'(ren), 32'd4);
    chk("to_writes", 32'(wr), 32'd0);
    chk("to_latency", 32'(lat), 32'd5);
    @(negedge clk);
    chk("to_busy_after", {31'd0, busy_t}, 32'd0);
    chk("to_error_after", {31'd0, error_t}, 32'd0);
    wait_idle();

    // Clamp to 32 words with the address wrapping through zero.
    load(32'hFFFF_FFFE, 6'd40, 0);
    wait_idle();

    // Zero-length load: done in cycle 1, no memory traffic.
    load(32'h0000_0700, 6'd0, 0);
    wait_idle();

    // Second start while busy is ignored; stray mem_ready is ignored too.
    stray = 1'b1;
    load(32'h0000_0300, 6'd4, 0);
    @(negedge clk);
    stray_start(32'h0000_5000, 6'd7);
    wait_idle();
    stray = 1'b0;

    // Reset during the write of the second word: no done, outputs cleared.
    load(32'h0000_0400, 6'd4, 0);
    k = 0;
    while (!(write && write_addr == 5'd1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_write1", {31'd0, write && write_addr == 5'd1}, 32'd1);
    #2 nrst = 1'b0;
    #1 chk_outputs_zero("midrst");
    q_addr.delete();
    q_wr.delete();
    q_done.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    load(32'h0000_0500, 6'd2, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("left_addr", 32'(q_addr.size()), 32'd0);
    chk("left_write", 32'(q_wr.size()), 32'd0);
    chk("left_done", 32'(q_done.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
